// File: rtl/fnd_pkg.sv
// Shared constants, snapshot layout and BCD helpers for the 4-digit FND scanner.
package fnd_pkg;

  localparam int SEL_W                = 2;
  localparam int SCAN_COUNT_DEFAULT   = 100_000;
  localparam int DP_THRESHOLD_DEFAULT = 50;

  localparam logic [3:0] COM_OFF   = 4'b1111;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef struct packed {
    logic       mode;
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
  } snap_t;

  function automatic logic [3:0] dec_ones(input logic [6:0] v);
    return 4'(v % 7'd10);
  endfunction

  // Tens are also reduced mod 10 so out-of-range values still map to a digit.
  function automatic logic [3:0] dec_tens(input logic [6:0] v);
    return 4'((v / 7'd10) % 7'd10);
  endfunction

endpackage

// File: rtl/fnd_seg_decoder.sv
// Combinational digit + decimal-point to active-low segment code {dp,g,f,e,d,c,b,a}.
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_dp_n,
  output logic [7:0] o_seg
);

  logic [7:0] w_code;

  // Digit lookup; codes carry dp=1 so the dp input can pull bit 7 low.
  always_comb begin
    w_code = SEG_BLANK;
    case (i_digit)
      4'd0:    w_code = SEG_0;
      4'd1:    w_code = SEG_1;
      4'd2:    w_code = SEG_2;
      4'd3:    w_code = SEG_3;
      4'd4:    w_code = SEG_4;
      4'd5:    w_code = SEG_5;
      4'd6:    w_code = SEG_6;
      4'd7:    w_code = SEG_7;
      4'd8:    w_code = SEG_8;
      4'd9:    w_code = SEG_9;
      default: w_code = SEG_BLANK;
    endcase
  end

  assign o_seg = {w_code[7] & i_dp_n, w_code[6:0]};

endmodule

// File: rtl/fnd_controller.sv
// Time-multiplexed 4-digit common-anode FND driver showing sec.msec or hour.min
// from a per-frame snapshot, with a blinking decimal point on the third digit.
module fnd_controller
  import fnd_pkg::*;
#(
  parameter int SCAN_COUNT   = SCAN_COUNT_DEFAULT,
  parameter int DP_THRESHOLD = DP_THRESHOLD_DEFAULT
)
(
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_mode,
  input  logic [6:0] msec,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  output logic [3:0] fnd_com,
  output logic [7:0] fnd_data
);

  localparam int              CNT_W    = (SCAN_COUNT > 1) ? $clog2(SCAN_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_COUNT - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = {SEL_W{1'b1}};
  localparam logic [6:0]       DP_LIM   = 7'(DP_THRESHOLD);

  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_digit_sel;
  snap_t            r_snap;
  logic [3:0]       r_com;
  logic [7:0]       r_data;

  logic       w_slot_end;
  logic       w_frame_end;
  logic [6:0] w_lo;
  logic [6:0] w_hi;
  logic [3:0] w_digit;
  logic       w_dp_n;
  logic [7:0] w_seg;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_digit_sel == SEL_LAST);

  // Slot timer and digit selector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_digit_sel <= '0;
    end else if (w_slot_end) begin
      r_cnt       <= '0;
      r_digit_sel <= r_digit_sel + SEL_W'(1);
    end else begin
      r_cnt       <= r_cnt + CNT_W'(1);
    end
  end

  // Latch all inputs together at the frame boundary so one frame never mixes samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
    end else if (w_frame_end) begin
      r_snap <= {sw_mode, msec, sec, min, hour};
    end else begin
      r_snap <= r_snap;
    end
  end

  // Pick the low/high pair for the current view and split the selected digit.
  always_comb begin
    w_lo    = 7'd0;
    w_hi    = 7'd0;
    w_digit = 4'd0;
    if (r_snap.mode) begin
      w_lo = {1'b0, r_snap.min};
      w_hi = {2'b00, r_snap.hour};
    end else begin
      w_lo = r_snap.msec;
      w_hi = {1'b0, r_snap.sec};
    end
    case (r_digit_sel)
      2'd0:    w_digit = dec_ones(w_lo);
      2'd1:    w_digit = dec_tens(w_lo);
      2'd2:    w_digit = dec_ones(w_hi);
      2'd3:    w_digit = dec_tens(w_hi);
      default: w_digit = 4'd0;
    endcase
  end

  // Decimal point blinks on the separator digit during the first half of each second.
  always_comb begin
    w_dp_n = 1'b1;
    if ((r_digit_sel == 2'd2) && (r_snap.msec < DP_LIM)) begin
      w_dp_n = 1'b0;
    end else begin
      w_dp_n = 1'b1;
    end
  end

  fnd_seg_decoder u_seg_decoder (
    .i_digit (w_digit),
    .i_dp_n  (w_dp_n),
    .o_seg   (w_seg)
  );

  // Registered display outputs, one clock behind the digit selector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_com  <= COM_OFF;
      r_data <= SEG_BLANK;
    end else begin
      r_com  <= ~(4'b0001 << r_digit_sel);
      r_data <= w_seg;
    end
  end

  assign fnd_com  = r_com;
  assign fnd_data = r_data;

endmodule
